// File: rtl/irq_wb8.sv
// ============================================================================
// Module      : irq_wb8
// Description : Edge-triggered interrupt controller on an 8-bit Wishbone bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_wb8 #(
  parameter int NUM_IRQ = 4
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic [1:0]         ADR_I,
  input  logic [7:0]         DAT_I,
  input  logic               STB_I,
  input  logic               WE_I,
  output logic [7:0]         DAT_O,
  output logic               ACK_O,
  input  logic [NUM_IRQ-1:0] I_irq,
  output logic               O_interrupt
);

  localparam logic [1:0] C_ADR_PENDING = 2'd0;
  localparam logic [1:0] C_ADR_ENABLE  = 2'd1;
  localparam logic [1:0] C_ADR_ACTIVE  = 2'd2;
  localparam logic [1:0] C_ADR_VECTOR  = 2'd3;

  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [7:0]         dat_q, dat_d;
  logic               ack_q, ack_d;
  logic               irq_q, irq_d;

  logic               access;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] active;
  logic [2:0]         vec_idx;
  logic [7:0]         pend8, en8, act8, vec8;
  logic               w_unused_dat;

  // Upper data bits are don't-care for narrow configurations.
  assign w_unused_dat = ^DAT_I;

  assign access = STB_I & ~ack_q;
  assign rise   = s2_q & ~s3_q;
  assign active = pending_q & enable_q;

  always_comb begin
    w1c_mask  = '0;
    enable_d  = enable_q;
    if (access && WE_I && (ADR_I == C_ADR_PENDING)) w1c_mask = DAT_I[NUM_IRQ-1:0];
    if (access && WE_I && (ADR_I == C_ADR_ENABLE))  enable_d = DAT_I[NUM_IRQ-1:0];
    // A new edge in the same cycle as its clear keeps the bit pending.
    pending_d = (pending_q & ~w1c_mask) | rise;
  end

  // Lowest index wins, so scan from the top down and let lower hits overwrite.
  always_comb begin
    vec_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    pend8 = '0;
    en8   = '0;
    act8  = '0;
    pend8[NUM_IRQ-1:0] = pending_q;
    en8[NUM_IRQ-1:0]   = enable_q;
    act8[NUM_IRQ-1:0]  = active;
    vec8  = (|active) ? {1'b1, 4'b0000, vec_idx} : 8'h00;
  end

  always_comb begin
    dat_d = dat_q;
    if (access) begin
      case (ADR_I)
        C_ADR_PENDING: dat_d = pend8;
        C_ADR_ENABLE:  dat_d = en8;
        C_ADR_ACTIVE:  dat_d = act8;
        C_ADR_VECTOR:  dat_d = vec8;
        default:       dat_d = 8'h00;
      endcase
    end
    ack_d = access;
    irq_d = |active;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      dat_q     <= 8'h00;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      s1_q      <= I_irq;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign DAT_O       = dat_q;
  assign ACK_O       = ack_q;
  assign O_interrupt = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_wb8.sv
// ============================================================================
// Module      : tb_irq_wb8
// Description : Self-checking bench for irq_wb8 with an edge-history model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_wb8;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   adr;
  logic [7:0]   dat;
  logic         stb;
  logic         we;
  logic [7:0]   dat_o;
  logic         ack_o;
  logic [N-1:0] irq;
  logic         oint;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: register contents plus the raw input samples of recent edges.
  logic [N-1:0] m_pend, m_en;
  logic [7:0]   m_dat;
  logic         m_ack, m_oint, m_rd;
  logic [N-1:0] hist [3];

  irq_wb8 #(.NUM_IRQ(N)) dut (
    .CLK_I(clk), .RST_I(rst), .ADR_I(adr), .DAT_I(dat), .STB_I(stb),
    .WE_I(we), .DAT_O(dat_o), .ACK_O(ack_o), .I_irq(irq), .O_interrupt(oint)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_reg(input logic [1:0] a);
    logic [N-1:0] act;
    logic [7:0]   v;
    act = m_pend & m_en;
    v = 8'h00;
    case (a)
      2'd0: v = 8'(m_pend);
      2'd1: v = 8'(m_en);
      2'd2: v = 8'(act);
      default: begin
        for (int i = N - 1; i >= 0; i--) if (act[i]) v = 8'h80 + 8'(i);
      end
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_dat = 8'h00; m_ack = 1'b0; m_oint = 1'b0; m_rd = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // Edge seen by the design at edge k: input high at k-2 and low at k-3.
  task automatic model_edge();
    logic         acc;
    logic [N-1:0] clr;
    logic [7:0]   rv;
    logic         noint;
    acc   = stb && !m_ack;
    rv    = model_reg(adr);
    noint = |(m_pend & m_en);
    clr   = '0;
    if (acc && we && adr == 2'd0) clr = dat[N-1:0];
    if (acc && we && adr == 2'd1) m_en = dat[N-1:0];
    m_pend = (m_pend & ~clr) | (hist[1] & ~hist[2]);
    if (acc) begin
      m_dat = rv;
      m_rd  = !we;
    end
    m_ack  = acc;
    m_oint = noint;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = irq;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    stb = 1'b1; we = 1'b1; adr = a; dat = d;
    step();
    stb = 1'b0; we = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    stb = 1'b1; we = 1'b0; adr = a;
    step();
    d = dat_o;
    stb = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; stb = 0; we = 0; adr = 0; dat = 0; irq = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    bus_write(2'd1, 8'h01);
    irq = 4'h1;
    repeat (5) step();
    stb = 1'b1; we = 1'b0; adr = 2'd1;
    step();
    // Mid-cycle asynchronous reset while ACK, DAT_O and O_interrupt are all high.
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b expected 0", ack_o); end
    n_cmp++; if (dat_o !== 8'h00) begin n_err++; $display("FAIL rst_dat: got %h expected 00", dat_o); end
    n_cmp++; if (oint !== 1'b0) begin n_err++; $display("FAIL rst_oint: got %b expected 0", oint); end
    stb = 1'b0; irq = '0;
    model_reset();
    #2 rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL rst_reg%0d: got %h expected 00", a, d); end
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    bus_write(2'd1, 8'h01);
    irq = 4'h1;
    step();              // E0
    irq = '0;
    step(); step();      // E1, E2
    n_cmp++; if (oint !== 1'b0) begin n_err++; $display("FAIL single_early: got %b expected 0", oint); end
    step();              // E3
    n_cmp++; if (oint !== 1'b1) begin n_err++; $display("FAIL single_oint: got %b expected 1", oint); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL single_pend: got %h expected 01", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL single_active: got %h expected 01", d); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 8'h80) begin n_err++; $display("FAIL single_vector: got %h expected 80", d); end
    bus_write(2'd0, 8'h01);
    n_cmp++; if (oint !== 1'b0) begin n_err++; $display("FAIL single_clear: got %b expected 0", oint); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    bus_write(2'd1, 8'h0A);
    irq = 4'hF;
    step();
    irq = '0;
    repeat (4) step();
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'h0F) begin n_err++; $display("FAIL prio_pend: got %h expected 0F", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 8'h0A) begin n_err++; $display("FAIL prio_active: got %h expected 0A", d); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 8'h81) begin n_err++; $display("FAIL prio_vec1: got %h expected 81", d); end
    bus_write(2'd0, 8'h02);
    bus_read(2'd3, d);
    n_cmp++; if (d !== 8'h83) begin n_err++; $display("FAIL prio_vec3: got %h expected 83", d); end
    bus_write(2'd0, 8'h08);
    n_cmp++; if (oint !== 1'b0) begin n_err++; $display("FAIL prio_oint: got %b expected 0", oint); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL prio_vec0: got %h expected 00", d); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'h05) begin n_err++; $display("FAIL prio_left: got %h expected 05", d); end
  endtask

  task automatic test_level();
    logic [7:0] d;
    bus_write(2'd0, 8'h0F);
    irq = 4'h4;
    repeat (4) step();
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'h04) begin n_err++; $display("FAIL level_first: got %h expected 04", d); end
    bus_write(2'd0, 8'h04);
    repeat (40) step();
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL level_held: got %h expected 00", d); end
    irq = '0;
    repeat (3) step();
    irq = 4'h4;
    repeat (4) step();
    irq = '0;
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'h04) begin n_err++; $display("FAIL level_again: got %h expected 04", d); end
    bus_write(2'd0, 8'h04);
  endtask

  task automatic test_collision();
    logic [7:0] d;
    irq = 4'h1;
    step();              // E0
    irq = '0;
    step();              // E1
    stb = 1'b1; we = 1'b1; adr = 2'd0; dat = 8'h01;
    step();              // E2: edge sets the bit while W1C acks
    stb = 1'b0; we = 1'b0;
    step();
    bus_read(2'd0, d);
    n_cmp++; if (d[0] !== 1'b1) begin n_err++; $display("FAIL collision: got %b expected 1", d[0]); end
  endtask

  task automatic test_handshake();
    logic [7:0] d;
    stb = 1'b1; we = 1'b0; adr = 2'd1;
    n_cmp++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL hs_idle: got %b expected 0", ack_o); end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++;
      if (ack_o !== ((k % 2) == 0)) begin n_err++; $display("FAIL hs_ack%0d: got %b expected %b", k, ack_o, (k % 2) == 0); end
      if (ack_o) begin
        n_cmp++;
        if (dat_o !== 8'h0A) begin n_err++; $display("FAIL hs_dat%0d: got %h expected 0A", k, dat_o); end
      end
    end
    stb = 1'b0;
    step();
    bus_write(2'd2, 8'hFF);
    bus_write(2'd3, 8'hFF);
    bus_read(2'd0, d);
    n_cmp++; if (d !== 8'(m_pend)) begin n_err++; $display("FAIL ro_pend: got %h expected %h", d, 8'(m_pend)); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 8'h0A) begin n_err++; $display("FAIL ro_en: got %h expected 0A", d); end
    bus_write(2'd1, 8'hFF);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 8'h0F) begin n_err++; $display("FAIL en_width: got %h expected 0F", d); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) irq = N'($urandom);
      stb = ($urandom_range(0, 2) != 0);
      we  = ($urandom_range(0, 2) == 0);
      adr = 2'($urandom);
      dat = 8'($urandom);
      step();
      n_cmp++; if (ack_o !== m_ack) begin n_err++; $display("FAIL rnd_ack@%0d: got %b expected %b", c, ack_o, m_ack); end
      n_cmp++; if (oint !== m_oint) begin n_err++; $display("FAIL rnd_oint@%0d: got %b expected %b", c, oint, m_oint); end
      if (m_ack && m_rd) begin
        n_cmp++;
        if (dat_o !== m_dat) begin n_err++; $display("FAIL rnd_dat@%0d: got %h expected %h", c, dat_o, m_dat); end
      end
    end
    stb = 1'b0; we = 1'b0; irq = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_level();
    test_collision();
    test_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_wb8.md
# irq_wb8

Edge-triggered interrupt controller on the 8-bit Wishbone bus. It collects up to eight asynchronous interrupt sources (timer, UART, SPI, external pins) and latches each rising edge as pending. It masks the pending set with a software enable register and drives the single CPU interrupt input. It sits in the I/O window as a peripheral behind the bus arbiter; its `O_interrupt` replaces the direct timer-to-CPU interrupt wire.

## Interface
- `NUM_IRQ`, default 4: number of interrupt sources, 1..8; unused register bits read 0 and ignore writes.
- `CLK_I` input 1: system clock.
- `RST_I` input 1: reset, asynchronous, active-high.
- `ADR_I` input 2: register select.
- `DAT_I` input 8: write data.
- `STB_I` input 1: bus strobe, already qualified by the address decoder.
- `WE_I` input 1: 1 = write, 0 = read.
- `DAT_O` output 8: registered read data.
- `ACK_O` output 1: registered single-cycle acknowledge.
- `I_irq` input NUM_IRQ: raw interrupt sources, asynchronous, active-high level.
- `O_interrupt` output 1: registered interrupt request to CPU, active-high.

## Operation
- Each `I_irq[i]` passes a 2-flop synchronizer (s1, s2), then a third flop s3. Rising edge = s2 & !s3.
- A rising edge sets `pending[i]`. Levels are not tracked: a source held high yields exactly one pending event.
- Register map, by `ADR_I`:
  - 0 PENDING: read returns pending. Write is write-1-to-clear; bits written 0 are unchanged.
  - 1 ENABLE: read/write mask.
  - 2 ACTIVE: read-only, pending & enable. Writes are ignored.
  - 3 VECTOR: read-only. Bit 7 = any active. Bits 2:0 = lowest active index; lowest index has highest priority. Bits 6:3 = 0. Reads 0x00 when none active. Writes are ignored.
- Reads have no side effects; pending is never cleared by a read.
- Simultaneous new edge and W1C of the same bit in one cycle: set wins, and the bit remains pending.
- Clearing ENABLE does not clear pending. Re-enabling a still-pending bit re-raises `O_interrupt`.
- `O_interrupt` <= |(pending & enable), registered each cycle.
- Reset, asynchronous, clears:
  - synchronizer flops s1/s2/s3 = 0
  - pending = 0, enable = 0
  - `DAT_O` = 0x00, `ACK_O` = 0, `O_interrupt` = 0
- Reset asserted mid-transfer aborts it: no ack is issued, and a write in progress has no effect.
- A source that is already high when reset is released produces an edge about 3 cycles later, because s3 resets to 0. This is intended: a source asserted at boot is seen once.

## Timing
- Bus handshake:
  - On a clock edge with `STB_I`=1 and `ACK_O`=0, the block performs the write (if `WE_I`), loads `DAT_O` with the read value, and sets `ACK_O`=1.
  - The next edge always clears `ACK_O`.
  - Result: ack latency is 1 cycle, and each access is acknowledged exactly once. A strobe held high gets an ack on every other cycle.
- `DAT_O` holds its last value outside acks. On write cycles, `DAT_O` is unspecified but stable.
- Write effects are visible on the edge that raises `ACK_O`. A read on the next access returns the updated value.
- Interrupt latency: `I_irq` rises before edge E0, then:
  - s1 at E0
  - s2 at E1
  - pending set at E2
  - `O_interrupt` at E3, i.e. 4 cycles worst-case after the input rises.
- Clear latency: W1C acked at edge E, so pending = 0 at E and `O_interrupt` = 0 at E+1, provided no other active bit remains.
- ACTIVE and VECTOR reads sample pending/enable as of the ack edge, before that edge's updates.

## Test plan
- Reset: assert `RST_I` asynchronously mid-cycle. Expect `DAT_O`=0, `ACK_O`=0, `O_interrupt`=0 immediately. Read regs 0..3 after release; expect all 0x00.
- Single source: write ENABLE=0x01, pulse `I_irq[0]` high for 1 cycle. Expect `O_interrupt`=1 exactly 4 cycles after the rise. Then expect PENDING=0x01, ACTIVE=0x01, VECTOR=0x80. W1C 0x01 to reg 0; expect `O_interrupt`=0 one cycle after ack.
- Priority and mask: ENABLE=0x0A, pulse `I_irq[3:0]`=0xF. Expect PENDING=0x0F, ACTIVE=0x0A, VECTOR=0x81. Clear bit 1; expect VECTOR=0x83. Clear bit 3; expect VECTOR=0x00 and `O_interrupt`=0. PENDING must still read 0x05.
- Level held: hold `I_irq[2]`=1 for 50 cycles, clearing pending after it sets. Expect pending stays 0 (exactly one event). Drop and re-raise the input; expect pending bit 2 sets again.
- Set/clear collision: time a W1C of bit 0 so its ack edge coincides with the synchronized edge of a new `I_irq[0]` pulse. Expect PENDING bit 0 = 1 afterwards.
- Handshake: hold `STB_I`=1 with `WE_I`=0 for 6 cycles. Expect `ACK_O` pattern 0,1,0,1,0,1, with `DAT_O` valid on each ack. Writes of 0xFF to reg 2 or 3 must change nothing. With `NUM_IRQ`=4, ENABLE write 0xFF reads back 0x0F.
